// File: rtl/e_bus_cycle_ctrl.sv
// Turns the delayed 6809 E clocks into per-cycle memory strobes for an address window,
// with an E-clock stall watchdog that parks the strobes inactive.
module e_bus_cycle_ctrl #(
  parameter logic [15:0] ADDR_BASE = 16'hE000,
  parameter logic [15:0] ADDR_MASK = 16'hE000,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_e_short,
  input  logic        i_e_long,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  output logic        o_mem_cs_n,
  output logic        o_mem_oe_n,
  output logic        o_mem_we_n,
  output logic        o_data_oe,
  output logic        o_cycle_done,
  output logic        o_abort,
  output logic        o_e_stuck
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WD_W  = 16;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             es_q, el_q, arm_q;
  logic             rw_q, rw_d;
  logic             ab_q, ab_d;
  logic             cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic             doe_q, doe_d, done_q, done_d, abort_q, abort_d, stuck_q, stuck_d;

  logic rise_s, fall_s, fall_l, hit, trip;

  // arm_q masks the first cycle after reset so a level already high is not taken as a rise
  assign rise_s = arm_q &  i_e_short & ~es_q;
  assign fall_s = arm_q & ~i_e_short &  es_q;
  assign fall_l = arm_q & ~i_e_long  &  el_q;
  assign hit    = (i_addr & ADDR_MASK) == ADDR_BASE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
      arm_q   <= 1'b0;
      rw_q    <= 1'b0;
      ab_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      es_q    <= i_e_short;
      el_q    <= i_e_long;
      arm_q   <= 1'b1;
      rw_q    <= rw_d;
      ab_q    <= ab_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      stuck_q <= stuck_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    ab_d    = ab_q;
    cs_n_d  = cs_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    doe_d   = doe_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    // Watchdog: any short-E edge restarts it; saturates at TIMEOUT
    if (rise_s || fall_s)          wd_d = '0;
    else if (wd_q == WD_W'(TIMEOUT)) wd_d = wd_q;
    else                           wd_d = wd_q + WD_W'(1);
    trip    = ~(rise_s | fall_s) & (wd_d == WD_W'(TIMEOUT));
    stuck_d = trip;

    case (state_q)
      IDLE: begin
        if (rise_s && hit) begin
          rw_d    = i_rw;
          ab_d    = 1'b0;
          cnt_d   = CNT_W'(SETUP_CYC);
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // fall_l wins over both fall_s and the counter expiring
        if (fall_l) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          doe_d   = 1'b0;
          done_d  = 1'b1;
          abort_d = 1'b1;
        end else if (fall_s) begin
          ab_d    = 1'b1;
          state_d = HOLD;
        end else if (cnt_q == '0) begin
          state_d = ACCESS;
          if (rw_q) begin
            oe_n_d = 1'b0;
            doe_d  = 1'b1;
          end else begin
            we_n_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        if (fall_l) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          doe_d   = 1'b0;
          done_d  = 1'b1;
        end else if (fall_s) begin
          we_n_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall_l) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          doe_d   = 1'b0;
          done_d  = 1'b1;
          abort_d = ab_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (trip) begin
      state_d = IDLE;
      cs_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      doe_d   = 1'b0;
      done_d  = 1'b0;
      abort_d = 1'b0;
    end
  end

  assign o_mem_cs_n   = cs_n_q;
  assign o_mem_oe_n   = oe_n_q;
  assign o_mem_we_n   = we_n_q;
  assign o_data_oe    = doe_q;
  assign o_cycle_done = done_q;
  assign o_abort      = abort_q;
  assign o_e_stuck    = stuck_q;

endmodule

// File: tb/tb_e_bus_cycle_ctrl.sv
// Directed bench for e_bus_cycle_ctrl: reads, writes, misses, aborts, watchdog and async reset.
// Outputs are compared as {cs_n, oe_n, we_n, data_oe, cycle_done, abort, e_stuck}.
module tb_e_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_s, e_l;
  logic [15:0] addr;
  logic        rw;
  logic        cs_n, oe_n, we_n, doe, done, abrt, stuck;
  logic [6:0]  outs;
  int          nchk = 0;
  int          nerr = 0;

  localparam logic [6:0] IDLE_V  = 7'b1110000;
  localparam logic [6:0] SETUP_V = 7'b0110000;
  localparam logic [6:0] RD_V    = 7'b0011000;
  localparam logic [6:0] WR_V    = 7'b0100000;
  localparam logic [6:0] DONE_V  = 7'b1110100;
  localparam logic [6:0] ABORT_V = 7'b1110110;
  localparam logic [6:0] STUCK_V = 7'b1110001;

  always #5 clk = ~clk;

  e_bus_cycle_ctrl #(
    .ADDR_BASE(16'hE000), .ADDR_MASK(16'hE000), .SETUP_CYC(2), .TIMEOUT(200)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_e_short(e_s), .i_e_long(e_l),
    .i_addr(addr), .i_rw(rw),
    .o_mem_cs_n(cs_n), .o_mem_oe_n(oe_n), .o_mem_we_n(we_n), .o_data_oe(doe),
    .o_cycle_done(done), .o_abort(abrt), .o_e_stuck(stuck)
  );

  assign outs = {cs_n, oe_n, we_n, doe, done, abrt, stuck};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    nchk++;
    assert (outs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; e_s = 1'b0; e_l = 1'b0; addr = 16'h0000; rw = 1'b1;
    step(2);
    chk("reset", IDLE_V);
    rst_n = 1'b1;
    step(3);
    chk("idle_after_reset", IDLE_V);

    // Read hit
    addr = 16'hE123; rw = 1'b1; e_s = 1'b1;
    step(1); chk("rd_cs_low", SETUP_V);
    e_l = 1'b1;
    step(2); chk("rd_setup_hold", SETUP_V);
    step(1); chk("rd_oe_on", RD_V);
    step(40); chk("rd_access", RD_V);
    e_s = 1'b0;
    step(1); chk("rd_hold_oe_kept", RD_V);
    step(2);
    e_l = 1'b0;
    step(1); chk("rd_done", DONE_V);
    step(1); chk("rd_done_one_cycle", IDLE_V);
    step(10);

    // Write hit
    addr = 16'hF000; rw = 1'b0; e_s = 1'b1;
    step(1); chk("wr_cs_low", SETUP_V);
    e_l = 1'b1;
    step(2); chk("wr_setup_hold", SETUP_V);
    step(1); chk("wr_we_on", WR_V);
    step(20); chk("wr_access", WR_V);
    e_s = 1'b0;
    step(1); chk("wr_we_off", SETUP_V);
    step(2);
    e_l = 1'b0;
    step(1); chk("wr_done", DONE_V);
    step(1); chk("wr_idle", IDLE_V);
    step(10);

    // Miss
    addr = 16'h1000; rw = 1'b1; e_s = 1'b1;
    step(1); chk("miss_rise", IDLE_V);
    e_l = 1'b1;
    step(20); chk("miss_high", IDLE_V);
    e_s = 1'b0;
    step(2);
    e_l = 1'b0;
    step(1); chk("miss_no_done", IDLE_V);
    step(10);

    // Short E: fall_s during SETUP, then fall_l later
    addr = 16'hE123; rw = 1'b1; e_s = 1'b1;
    step(1); chk("short_cs_low", SETUP_V);
    e_s = 1'b0; e_l = 1'b1;
    step(1); chk("short_hold_no_oe", SETUP_V);
    step(1);
    e_l = 1'b0;
    step(1); chk("short_abort", ABORT_V);
    step(1); chk("short_abort_one_cycle", IDLE_V);
    step(10);

    // fall_s and fall_l together as the setup count reaches zero
    addr = 16'hE555; rw = 1'b0; e_s = 1'b1;
    step(1);
    e_l = 1'b1;
    step(2); chk("prio_setup_cnt0", SETUP_V);
    e_s = 1'b0; e_l = 1'b0;
    step(1); chk("prio_fall_l_abort", ABORT_V);
    step(10);

    // fall_s and fall_l together in ACCESS: done, no abort
    addr = 16'hE000; rw = 1'b0; e_s = 1'b1;
    step(1);
    e_l = 1'b1;
    step(3); chk("both_fall_access", WR_V);
    e_s = 1'b0; e_l = 1'b0;
    step(1); chk("both_fall_done", DONE_V);
    step(10);

    // Watchdog: E held high
    addr = 16'hE123; rw = 1'b1; e_s = 1'b1;
    step(1); chk("wd_cs_low", SETUP_V);
    e_l = 1'b1;
    step(3); chk("wd_access", RD_V);
    step(196); chk("wd_before_trip", RD_V);
    step(1); chk("wd_trip", STUCK_V);
    step(49); chk("wd_stuck_held", STUCK_V);
    e_s = 1'b0;
    step(1); chk("wd_clear", IDLE_V);
    e_l = 1'b0;
    step(1); chk("wd_no_done", IDLE_V);
    step(5);
    e_s = 1'b1;
    step(1); chk("wd_fresh_cs", SETUP_V);
    e_l = 1'b1;
    step(3); chk("wd_fresh_oe", RD_V);
    e_s = 1'b0;
    step(1);
    e_l = 1'b0;
    step(1); chk("wd_fresh_done", DONE_V);
    step(10);

    // Asynchronous reset during ACCESS, released with E still high
    addr = 16'hE123; rw = 1'b1; e_s = 1'b1;
    step(1);
    e_l = 1'b1;
    step(3); chk("rst_pre_access", RD_V);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", IDLE_V);
    #2 rst_n = 1'b1;
    step(3); chk("rst_no_false_rise", IDLE_V);
    e_s = 1'b0; e_l = 1'b0;
    step(3); chk("rst_fall_ignored", IDLE_V);
    e_s = 1'b1;
    step(1); chk("rst_next_cs", SETUP_V);
    e_l = 1'b1;
    step(3); chk("rst_next_oe", RD_V);
    e_s = 1'b0;
    step(1);
    e_l = 1'b0;
    step(1); chk("rst_next_done", DONE_V);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/e_bus_cycle_ctrl.md
# e_bus_cycle_ctrl

Downstream consumer of the `e_clk_delay` outputs. It turns the short- and long-delayed 6809 E clock into a per-bus-cycle sequence of memory strobes: chip select, output enable, write enable and CPU data-bus drive enable. Strobes apply only to accesses inside a parameterised address window. A watchdog flags a stalled E clock and parks all strobes inactive.

## Interface
Parameters:
- ADDR_BASE, 16'hE000, window base; a hit is `(i_addr & ADDR_MASK) == ADDR_BASE`
- ADDR_MASK, 16'hE000, address bits compared for a window hit
- SETUP_CYC, 2, i_clk cycles that o_mem_cs_n is low before OE/WE assert (1..15)
- TIMEOUT, 200, i_clk cycles without any i_e_short edge before the stall flag sets (1..65535)

Ports:
- i_clk  in  1  fast PLL clock (100 MHz); the only clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_e_short  in  1  short-delayed E from e_clk_delay; registered in the i_clk domain, no resync
- i_e_long  in  1  long-delayed E from e_clk_delay; registered in the i_clk domain; rises and falls no earlier than i_e_short
- i_addr  in  16  CPU address; stable at the i_e_short rising edge
- i_rw  in  1  CPU R/W (1 = read); stable at the i_e_short rising edge
- o_mem_cs_n  out  1  memory chip select, active-low
- o_mem_oe_n  out  1  memory output enable, active-low
- o_mem_we_n  out  1  memory write enable, active-low
- o_data_oe  out  1  drive memory data onto the CPU bus (reads only)
- o_cycle_done  out  1  one-cycle pulse when a window cycle completes or aborts
- o_abort  out  1  one-cycle pulse coincident with o_cycle_done if OE/WE never asserted
- o_e_stuck  out  1  E-clock stall flag

## Operation
- Edge detection uses one history register per input: rise_s, fall_s, fall_l.
- All outputs are registered. A strobe change decided in cycle N appears after the clock edge that ends cycle N.
- FSM states are IDLE, SETUP, ACCESS, HOLD.
- IDLE
  - On rise_s with a window hit: latch i_rw into rw_q, load the setup counter with SETUP_CYC, go to SETUP, drive o_mem_cs_n to 0.
  - On rise_s with a miss: stay in IDLE; no strobe changes.
- SETUP
  - Counter decrements each cycle. On reaching 0: go to ACCESS.
  - rw_q = 1: drive o_mem_oe_n to 0 and o_data_oe to 1.
  - rw_q = 0: drive o_mem_we_n to 0.
- ACCESS
  - On fall_s: drive o_mem_we_n to 1 (writes), go to HOLD.
  - o_mem_oe_n and o_data_oe stay asserted in ACCESS and HOLD to cover the read-data hold time past E fall.
- HOLD
  - On fall_l: deassert all strobes (cs_n = oe_n = we_n = 1, data_oe = 0), pulse o_cycle_done, go to IDLE.
- Boundary cases:
  - fall_s during SETUP: OE/WE are never asserted. Go to HOLD with cs_n still low. The cycle ends with o_cycle_done and o_abort both pulsing.
  - fall_s and fall_l in the same cycle, in SETUP or ACCESS: go directly to IDLE with all strobes deasserted. Pulse o_cycle_done, plus o_abort if in SETUP.
  - fall_l in the same cycle as the SETUP counter reaching 0: fall_l takes priority; done + abort.
  - rise_s outside IDLE (missed fall): ignored. The FSM continues and the watchdog covers persistent faults.
- Watchdog
  - A 16-bit counter clears on any rise_s or fall_s and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: o_e_stuck = 1, FSM forced to IDLE, all strobes deasserted, no o_cycle_done.
  - o_e_stuck clears in the cycle after the next i_e_short edge. That same edge is processed normally, so a rise with a window hit starts a cycle.
- Reset (asynchronous, any state, including mid-cycle)
  - FSM = IDLE, counters = 0, history registers = 0.
  - o_mem_cs_n = o_mem_oe_n = o_mem_we_n = 1; o_data_oe = o_cycle_done = o_abort = o_e_stuck = 0.
  - If i_e_short is already 1 at reset release, no rise is seen until the next genuine rising edge.

## Timing
- rise_s to o_mem_cs_n low: 1 i_clk cycle.
- o_mem_cs_n low to OE/WE assert: SETUP_CYC + 1 cycles.
- fall_s to o_mem_we_n high: 1 cycle.
- fall_l to all strobes inactive and o_cycle_done high: 1 cycle; o_cycle_done lasts exactly 1 cycle.
- Timeout: o_e_stuck rises TIMEOUT + 1 cycles after the last i_e_short edge.
- Combinational paths from inputs to outputs: none.

## Test plan
- Read hit (i_addr = 16'hE123, i_rw = 1; E 500 ns high / 500 ns low; long delay 30 ns) -> cs_n low 10 ns after E rise, oe_n low and data_oe high 30 ns later, all released 10 ns after i_e_long falls, one o_cycle_done pulse, o_abort = 0.
- Write hit (16'hF000, i_rw = 0) -> we_n low from 40 ns after rise until 10 ns after i_e_short falls; cs_n held until 10 ns after i_e_long falls.
- Miss (16'h1000) -> all strobes stay inactive, no o_cycle_done.
- E high only 20 ns (shorter than setup) -> OE/WE never assert; o_cycle_done and o_abort pulse together.
- E held high 2500 ns, TIMEOUT = 200 -> o_e_stuck = 1 at 2010 ns after the rise, strobes inactive; on the next E edge the flag clears and a fresh read completes normally.
- i_rst_n pulsed low during ACCESS -> all outputs at reset values immediately (asynchronous); the next full E cycle performs a normal access.
